// File: rtl/morse_pkg.sv
// Shared character codes, decoder FSM states and the Morse pattern lookup.
package morse_pkg;

    localparam logic [7:0] CH_INVALID = 8'd0;
    localparam logic [7:0] CH_A = 8'd1,  CH_B = 8'd2,  CH_C = 8'd3,  CH_D = 8'd4,  CH_E = 8'd5;
    localparam logic [7:0] CH_F = 8'd6,  CH_G = 8'd7,  CH_H = 8'd8,  CH_I = 8'd9,  CH_J = 8'd10;
    localparam logic [7:0] CH_K = 8'd11, CH_L = 8'd12, CH_M = 8'd13, CH_N = 8'd14, CH_O = 8'd15;
    localparam logic [7:0] CH_P = 8'd16, CH_Q = 8'd17, CH_R = 8'd18, CH_S = 8'd19, CH_T = 8'd20;
    localparam logic [7:0] CH_U = 8'd21, CH_V = 8'd22, CH_W = 8'd23, CH_X = 8'd24, CH_Y = 8'd25;
    localparam logic [7:0] CH_Z = 8'd26, CH_SPACE = 8'd27;
    localparam logic [7:0] CH_1 = 8'd28, CH_2 = 8'd29, CH_3 = 8'd30, CH_4 = 8'd31, CH_5 = 8'd32;
    localparam logic [7:0] CH_6 = 8'd33, CH_7 = 8'd34, CH_8 = 8'd35, CH_9 = 8'd36, CH_0 = 8'd37;
    localparam logic [7:0] CH_PLUS = 8'd38, CH_EQ = 8'd39, CH_SLASH = 8'd40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_LOOKUP,
        ST_PUSH,
        ST_SPACE_PUSH
    } morse_state_t;

    // First symbol sits at bit len-1, newest at bit 0; dot=0, dash=1.
    function automatic logic [7:0] morse_lookup(input logic [4:0] pattern, input logic [2:0] len);
        logic [4:0] mask;
        logic [7:0] code;
        mask = 5'((6'd1 << len) - 6'd1);
        code = CH_INVALID;
        case ({len, pattern & mask})
            {3'd1, 5'b00000}: code = CH_E;
            {3'd1, 5'b00001}: code = CH_T;
            {3'd2, 5'b00000}: code = CH_I;
            {3'd2, 5'b00001}: code = CH_A;
            {3'd2, 5'b00010}: code = CH_N;
            {3'd2, 5'b00011}: code = CH_M;
            {3'd3, 5'b00000}: code = CH_S;
            {3'd3, 5'b00001}: code = CH_U;
            {3'd3, 5'b00010}: code = CH_R;
            {3'd3, 5'b00011}: code = CH_W;
            {3'd3, 5'b00100}: code = CH_D;
            {3'd3, 5'b00101}: code = CH_K;
            {3'd3, 5'b00110}: code = CH_G;
            {3'd3, 5'b00111}: code = CH_O;
            {3'd4, 5'b00000}: code = CH_H;
            {3'd4, 5'b00001}: code = CH_V;
            {3'd4, 5'b00010}: code = CH_F;
            {3'd4, 5'b00100}: code = CH_L;
            {3'd4, 5'b00110}: code = CH_P;
            {3'd4, 5'b00111}: code = CH_J;
            {3'd4, 5'b01000}: code = CH_B;
            {3'd4, 5'b01001}: code = CH_X;
            {3'd4, 5'b01010}: code = CH_C;
            {3'd4, 5'b01011}: code = CH_Y;
            {3'd4, 5'b01100}: code = CH_Z;
            {3'd4, 5'b01101}: code = CH_Q;
            {3'd5, 5'b01111}: code = CH_1;
            {3'd5, 5'b00111}: code = CH_2;
            {3'd5, 5'b00011}: code = CH_3;
            {3'd5, 5'b00001}: code = CH_4;
            {3'd5, 5'b00000}: code = CH_5;
            {3'd5, 5'b10000}: code = CH_6;
            {3'd5, 5'b11000}: code = CH_7;
            {3'd5, 5'b11100}: code = CH_8;
            {3'd5, 5'b11110}: code = CH_9;
            {3'd5, 5'b11111}: code = CH_0;
            {3'd5, 5'b01010}: code = CH_PLUS;
            {3'd5, 5'b10001}: code = CH_EQ;
            {3'd5, 5'b10010}: code = CH_SLASH;
            default:          code = CH_INVALID;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/morse_char_fifo.sv
// Synchronous character FIFO; simultaneous push and pop are accepted when full.
module morse_char_fifo
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                     cclk,
    input  logic                     rstb,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/morse_stream_decoder.sv
// Touch-pad Morse decoder feeding a character FIFO.
// Optional MORSE_AUTOGAP_EN: idle-gap timer commits letters and inserts word spaces.
module morse_stream_decoder
    import morse_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEBOUNCE_CYC = 100000,
    parameter int unsigned DASH_CYC     = 85000000,
    parameter int unsigned GAP_CYC      = 170000000,
    parameter int unsigned MAX_SYMS     = 5,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          cclk,
    input  logic                          rstb,
    input  logic                          tap,
    input  logic                          space,
    input  logic                          send,
    output logic [7:0]                    char_data,
    output logic                          char_valid,
    input  logic                          char_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [2:0]                    sym_count,
    output logic [MAX_SYMS-1:0]           sym_pattern,
    output logic                          dot_pulse,
    output logic                          dash_pulse,
    output logic                          err_invalid
);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_THR  = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] DASH_THR = CNT_W'(DASH_CYC);

    morse_state_t state, state_nx;
    logic [CNT_W-1:0] tcnt;
    logic             is_dot_c, is_dash_c, sym_evt_c;
    logic             ovf;
    logic [4:0]       snap_pat;
    logic [2:0]       snap_len;
    logic             snap_ovf;
    logic [7:0]       code_q, lookup_code_c, push_data_c;
    logic             commit_c, push_c, err_c, set_pend_c, clr_pend_c, pend_eff_c;
    logic             room_c, pop_c, pending_space;
    logic             fifo_full, fifo_empty;
    logic             gap_send_c, gap_space_c;

    // Press classification happens on the first released cycle.
    always_comb begin
        is_dash_c = !tap && (tcnt > DASH_THR);
        is_dot_c  = !tap && (tcnt > DEB_THR) && !(tcnt > DASH_THR);
        sym_evt_c = is_dot_c || is_dash_c;
    end

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            tcnt       <= '0;
            dot_pulse  <= 1'b0;
            dash_pulse <= 1'b0;
        end else begin
            dot_pulse  <= is_dot_c;
            dash_pulse <= is_dash_c;
            if (!tap)                tcnt <= '0;
            else if (tcnt != CNT_MAX) tcnt <= tcnt + CNT_W'(1);
        end
    end

    // A symbol landing on the commit edge starts the next character.
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            sym_pattern <= '0;
            sym_count   <= '0;
            ovf         <= 1'b0;
        end else if (commit_c) begin
            sym_pattern <= sym_evt_c ? MAX_SYMS'(is_dash_c) : '0;
            sym_count   <= sym_evt_c ? 3'd1 : 3'd0;
            ovf         <= 1'b0;
        end else if (sym_evt_c) begin
            if (sym_count == 3'(MAX_SYMS)) begin
                ovf <= 1'b1;
            end else begin
                sym_pattern <= MAX_SYMS'({sym_pattern, is_dash_c});
                sym_count   <= sym_count + 3'd1;
            end
        end
    end

`ifdef MORSE_AUTOGAP_EN
    localparam logic [CNT_W-1:0] GAP_THR  = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] GAP2_THR = CNT_W'(2 * GAP_CYC);
    logic [CNT_W-1:0] gcnt;
    logic             char_since_space;

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            gcnt             <= '0;
            char_since_space <= 1'b0;
        end else begin
            if (sym_evt_c)                     gcnt <= '0;
            else if (!tap && gcnt != CNT_MAX)  gcnt <= gcnt + CNT_W'(1);
            if (push_c && state == ST_SPACE_PUSH) char_since_space <= 1'b0;
            else if (push_c && state == ST_PUSH)  char_since_space <= 1'b1;
        end
    end

    assign gap_send_c  = (gcnt == GAP_THR);
    assign gap_space_c = (gcnt == GAP2_THR) && char_since_space;
`else
    assign gap_send_c  = 1'b0;
    assign gap_space_c = 1'b0;
`endif

    always_ff @(posedge cclk) begin
        if (!rstb) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        commit_c      = 1'b0;
        push_c        = 1'b0;
        push_data_c   = code_q;
        err_c         = 1'b0;
        set_pend_c    = 1'b0;
        clr_pend_c    = 1'b0;
        pop_c         = char_valid && char_ready;
        room_c        = !fifo_full || pop_c;
        pend_eff_c    = pending_space || space || gap_space_c;
        lookup_code_c = morse_lookup(snap_pat, snap_len);
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (sym_count != 3'd0 && (send || space || gap_send_c)) begin
                    commit_c   = 1'b1;
                    set_pend_c = space;
                    state_nx   = ST_LOOKUP;
                end else if (space || gap_space_c) begin
                    state_nx = ST_SPACE_PUSH;
                end else begin
                    state_nx = (sym_count != 3'd0) ? ST_ACCUM : ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                set_pend_c = space || gap_space_c;
                if (lookup_code_c == CH_INVALID || snap_ovf) begin
                    err_c    = 1'b1;
                    state_nx = pend_eff_c ? ST_SPACE_PUSH : ST_IDLE;
                end else begin
                    state_nx = ST_PUSH;
                end
            end
            ST_PUSH: begin
                set_pend_c = space || gap_space_c;
                if (room_c) begin
                    push_c   = 1'b1;
                    state_nx = pend_eff_c ? ST_SPACE_PUSH : ST_IDLE;
                end
            end
            ST_SPACE_PUSH: begin
                set_pend_c  = space || gap_space_c;
                push_data_c = CH_SPACE;
                if (room_c) begin
                    push_c     = 1'b1;
                    clr_pend_c = 1'b1;
                    state_nx   = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            snap_pat      <= '0;
            snap_len      <= '0;
            snap_ovf      <= 1'b0;
            code_q        <= '0;
            pending_space <= 1'b0;
            err_invalid   <= 1'b0;
        end else begin
            err_invalid <= err_c;
            if (commit_c) begin
                snap_pat <= 5'(sym_pattern);
                snap_len <= sym_count;
                snap_ovf <= ovf;
            end
            if (state == ST_LOOKUP) code_q <= lookup_code_c;
            if (clr_pend_c)      pending_space <= 1'b0;
            else if (set_pend_c) pending_space <= 1'b1;
        end
    end

    assign char_valid = !fifo_empty;

    morse_char_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .cclk  (cclk),
        .rstb  (rstb),
        .push  (push_c),
        .din   (push_data_c),
        .pop   (pop_c),
        .dout  (char_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Directed bench for morse_stream_decoder; the gap test runs when MORSE_AUTOGAP_EN is defined.
module tb_morse_stream_decoder;

    logic       cclk = 1'b0;
    logic       rstb;
    logic       tap, space, send, char_ready;
    logic [7:0] char_data;
    logic       char_valid;
    logic [2:0] fifo_count;
    logic [2:0] sym_count;
    logic [4:0] sym_pattern;
    logic       dot_pulse, dash_pulse, err_invalid;

    int total = 0;
    int bad   = 0;
    int n_dot = 0, n_dash = 0, n_err = 0;
    logic [7:0] rx_q[$];

    morse_stream_decoder #(
        .CNT_W(7), .DEBOUNCE_CYC(4), .DASH_CYC(20), .GAP_CYC(50),
        .MAX_SYMS(5), .FIFO_DEPTH(4)
    ) dut (
        .cclk(cclk), .rstb(rstb), .tap(tap), .space(space), .send(send),
        .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
        .fifo_count(fifo_count), .sym_count(sym_count), .sym_pattern(sym_pattern),
        .dot_pulse(dot_pulse), .dash_pulse(dash_pulse), .err_invalid(err_invalid)
    );

    always #5 cclk = ~cclk;

    // Pulse counters and accepted-character log, sampled mid-cycle.
    always @(negedge cclk) begin
        if (dot_pulse)   n_dot++;
        if (dash_pulse)  n_dash++;
        if (err_invalid) n_err++;
        if (rstb && char_valid && char_ready) rx_q.push_back(char_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hFF;
    endfunction

    task automatic step();
        @(posedge cclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_tap(input int n);
        tap = 1'b1;
        idle(n);
        tap = 1'b0;
    endtask

    task automatic pulse_send();
        send = 1'b1;
        step();
        send = 1'b0;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        idle(3);
        rstb = 1'b1;
        step();
    endtask

    task automatic commit_e();
        do_tap(10);
        idle(3);
        pulse_send();
        idle(4);
    endtask

    initial begin
        int b_dot, b_dash, b_err, b_rx;
        tap = 1'b0; space = 1'b0; send = 1'b0; char_ready = 1'b1; rstb = 1'b0;
        idle(3);
        check("rst_valid", 32'(char_valid), 32'd0);
        check("rst_data", 32'(char_data), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_syms", 32'(sym_count), 32'd0);
        check("rst_pulses", 32'({dot_pulse, dash_pulse, err_invalid}), 32'd0);
        rstb = 1'b1;
        step();

        // Dot then dash, send: 'A' visible three cycles after send.
        b_dot = n_dot; b_dash = n_dash; b_rx = rx_q.size();
        do_tap(10); idle(5); do_tap(30); idle(5);
        check("a_dot", n_dot - b_dot, 32'd1);
        check("a_dash", n_dash - b_dash, 32'd1);
        check("a_symcnt", 32'(sym_count), 32'd2);
        check("a_pattern", 32'(sym_pattern), 32'b01);
        pulse_send();
        check("a_lat1", 32'(char_valid), 32'd0);
        step();
        check("a_lat2", 32'(char_valid), 32'd0);
        step();
        check("a_lat3", 32'(char_valid), 32'd1);
        check("a_data", 32'(char_data), 32'd1);
        idle(2);
        check("a_rx", 32'(rx_at(b_rx)), 32'd1);

        // Debounce and counter saturation.
        do_reset();
        b_dot = n_dot; b_dash = n_dash; b_rx = rx_q.size();
        do_tap(3); idle(3);
        check("noise_pulses", (n_dot - b_dot) + (n_dash - b_dash), 32'd0);
        check("noise_syms", 32'(sym_count), 32'd0);
        do_tap(128); idle(3);
        check("sat_dash", n_dash - b_dash, 32'd1);
        check("sat_dot", n_dot - b_dot, 32'd0);
        check("sat_pattern", 32'({sym_count, sym_pattern}), 32'({3'd1, 5'b00001}));
        pulse_send(); idle(6);
        check("sat_rx_t", 32'(rx_at(b_rx)), 32'd20);

        // Invalid pattern and overlong pattern.
        do_reset();
        b_err = n_err; b_rx = rx_q.size();
        do_tap(10); idle(3); do_tap(10); idle(3); do_tap(30); idle(3); do_tap(30); idle(3);
        check("inv_pattern", 32'(sym_pattern), 32'b0011);
        pulse_send(); idle(5);
        check("inv_err", n_err - b_err, 32'd1);
        check("inv_count", 32'(fifo_count), 32'd0);
        for (int i = 0; i < 6; i++) begin
            do_tap(10); idle(3);
        end
        check("ovf_symcnt", 32'(sym_count), 32'd5);
        pulse_send(); idle(5);
        check("ovf_err", n_err - b_err, 32'd2);
        check("ovf_rx", rx_q.size() - b_rx, 32'd0);
        check("ovf_cleared", 32'(sym_count), 32'd0);

        // Back-pressure: five E's into a 4-deep FIFO.
        do_reset();
        char_ready = 1'b0; b_rx = rx_q.size();
        for (int i = 0; i < 5; i++) commit_e();
        idle(5);
        check("bp_count", 32'(fifo_count), 32'd4);
        check("bp_head", 32'(char_data), 32'd5);
        char_ready = 1'b1;
        idle(10);
        check("bp_rx_n", rx_q.size() - b_rx, 32'd5);
        for (int i = 0; i < 5; i++) check("bp_rx_e", 32'(rx_at(b_rx + i)), 32'd5);
        check("bp_drained", 32'(fifo_count), 32'd0);

        // Space and send together, then a lone space.
        do_reset();
        b_rx = rx_q.size();
        do_tap(10); idle(3);
        space = 1'b1; send = 1'b1;
        step();
        space = 1'b0; send = 1'b0;
        idle(8);
        check("sp_rx_n", rx_q.size() - b_rx, 32'd2);
        check("sp_rx0", 32'(rx_at(b_rx)), 32'd5);
        check("sp_rx1", 32'(rx_at(b_rx + 1)), 32'd27);
        space = 1'b1;
        step();
        space = 1'b0;
        idle(6);
        check("sp_lone_n", rx_q.size() - b_rx, 32'd3);
        check("sp_lone", 32'(rx_at(b_rx + 2)), 32'd27);

        // Reset while PUSH is active with three queued characters and a pending space.
        do_reset();
        char_ready = 1'b0; b_rx = rx_q.size();
        for (int i = 0; i < 3; i++) commit_e();
        check("mr_count3", 32'(fifo_count), 32'd3);
        do_tap(10); idle(3);
        space = 1'b1;
        step();
        space = 1'b0;
        step();
        rstb = 1'b0;
        step();
        check("mr_valid", 32'(char_valid), 32'd0);
        check("mr_outs", 32'({char_data, fifo_count, sym_count, sym_pattern}), 32'd0);
        check("mr_pulses", 32'({dot_pulse, dash_pulse, err_invalid}), 32'd0);
        rstb = 1'b1; char_ready = 1'b1;
        idle(6);
        check("mr_no_space", 32'(fifo_count), 32'd0);
        check("mr_rx", rx_q.size() - b_rx, 32'd0);

`ifdef MORSE_AUTOGAP_EN
        // Idle gap commits 'T', then one word space only.
        do_reset();
        b_rx = rx_q.size();
        do_tap(30);
        idle(160);
        check("gap_rx_n", rx_q.size() - b_rx, 32'd2);
        check("gap_t", 32'(rx_at(b_rx)), 32'd20);
        check("gap_space", 32'(rx_at(b_rx + 1)), 32'd27);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
